// File: rtl/uart_rx_ram_wr_pkg.sv
// Shared definitions for the UART-to-RAM write path.
// Widths are common with the RAM controller on the other port.
package uart_rx_ram_wr_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_e;

  function automatic logic addr_is_last(input logic [ADDR_W-1:0] addr);
    return (addr == {ADDR_W{1'b1}});
  endfunction

endpackage

// File: rtl/uart_rx_ram_wr_sync_2ff.sv
// Two-flop synchroniser for the asynchronous rx line.
// Both stages reset to the idle-high level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: two back-to-back flops, reset to line idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/uart_rx_ram_wr.sv
// 8N1 UART receiver that writes each good byte into consecutive
// addresses of a 256x8 RAM, flagging frame completion and stop-bit errors.
module uart_rx_ram_wr
  import uart_rx_ram_wr_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              frame_done,
  output logic              frame_err,
  output logic              busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_rx_ram_wr: CLK_FREQ/BAUD must be at least 4");
  end

  logic              rx_s;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  // Receiver FSM next state plus write-port and flag computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    din_d   = din_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = '0;
      addr_d  = '0;
    end else begin
      // Address advances the cycle after the strobe so the RAM sees a stable pair.
      if (we_q) begin
        addr_d = addr_q + ADDR_W'(1'b1);
      end else begin
        addr_d = addr_q;
      end

      unique case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            bit_d = '0;
            if (!rx_s) begin
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            if (bit_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_d = '0;
            if (rx_s) begin
              state_d = S_IDLE;
              we_d    = 1'b1;
              din_d   = shift_q;
              done_d  = addr_is_last(addr_q);
            end else begin
              state_d = S_WAIT_HIGH;
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1'b1);
          end
        end
        S_WAIT_HIGH: begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_HIGH;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign ram_we     = we_q;
  assign ram_addr   = addr_q;
  assign ram_din    = din_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_ram_wr.sv
// Directed bench for uart_rx_ram_wr. Runs at 16 clocks per bit so the
// full 256-byte sweep stays short; glitch and break lengths are scaled to match.
module tb_uart_rx_ram_wr;

  localparam int CPB       = 16;
  localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       clr;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  uart_rx_ram_wr #(
    .CLK_FREQ (1_843_200),
    .BAUD     (115_200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .clr        (clr),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int we_cnt = 0;
  int fe_cnt = 0;
  int fd_cnt = 0;
  int busy_cnt = 0;
  logic [7:0] fd_addr = 8'h00;
  logic [7:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];

  // Output monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt = we_cnt + 1;
      wr_addr_q.push_back(ram_addr);
      wr_data_q.push_back(ram_din);
    end
    if (frame_done) begin
      fd_cnt  = fd_cnt + 1;
      fd_addr = ram_addr;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] wa(input int i);
    if (i < wr_addr_q.size()) return 32'(wr_addr_q[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < wr_data_q.size()) return 32'(wr_data_q[i]);
    else return 32'hFFFF_FFFF;
  endfunction

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   32'(ram_we),     32'd0);
    chk({tag, "_addr"}, 32'(ram_addr),   32'd0);
    chk({tag, "_din"},  32'(ram_din),    32'd0);
    chk({tag, "_done"}, 32'(frame_done), 32'd0);
    chk({tag, "_err"},  32'(frame_err),  32'd0);
    chk({tag, "_busy"}, 32'(busy),       32'd0);
  endtask

  int b_we, b_fe, b_fd, b_q, b_busy, bad;

  initial begin
    rx    = 1'b1;
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte after reset.
    b_we = we_cnt; b_fe = fe_cnt; b_q = wr_addr_q.size();
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    chk("a5_we_cnt", 32'(we_cnt - b_we), 32'd1);
    chk("a5_addr",   wa(b_q), 32'h00);
    chk("a5_data",   wd(b_q), 32'hA5);
    chk("a5_err",    32'(fe_cnt - b_fe), 32'd0);
    chk("a5_next_addr", 32'(ram_addr), 32'd1);
    chk("a5_din_hold",  32'(ram_din), 32'hA5);
    chk("a5_idle",      32'(busy), 32'd0);

    // Full address sweep with wrap.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    b_we = we_cnt; b_fd = fd_cnt; b_q = wr_addr_q.size();
    for (int i = 0; i < 256; i++) send_frame(i[7:0], 1'b1);
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    chk("sweep_we_cnt", 32'(we_cnt - b_we), 32'd257);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (wa(b_q + i) !== 32'(i) || wd(b_q + i) !== 32'(i)) bad = bad + 1;
    end
    chk("sweep_bad_entries", 32'(bad), 32'd0);
    chk("sweep_done_cnt",  32'(fd_cnt - b_fd), 32'd1);
    chk("sweep_done_addr", 32'(fd_addr), 32'hFF);
    chk("wrap_addr", wa(b_q + 256), 32'h00);
    chk("wrap_data", wd(b_q + 256), 32'h3C);
    chk("wrap_next_addr", 32'(ram_addr), 32'd1);

    // Short low glitch: start bit rejected.
    b_we = we_cnt; b_fe = fe_cnt; b_busy = busy_cnt;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_we",   32'(we_cnt - b_we), 32'd0);
    chk("glitch_err",  32'(fe_cnt - b_fe), 32'd0);
    chk("glitch_busy_seen", 32'((busy_cnt - b_busy) != 0), 32'd1);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Bad stop bit followed by a break, then a good byte.
    b_we = we_cnt; b_fe = fe_cnt; b_q = wr_addr_q.size();
    send_frame(8'h55, 1'b0);
    repeat (200) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h77, 1'b1);
    repeat (4) @(negedge clk);
    chk("break_err_cnt", 32'(fe_cnt - b_fe), 32'd1);
    chk("break_we_cnt",  32'(we_cnt - b_we), 32'd1);
    chk("break_addr",    wa(b_q), 32'h01);
    chk("break_data",    wd(b_q), 32'h77);

    // Reset in the middle of data bit 4.
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    chk("midbyte_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    b_we = we_cnt; b_fe = fe_cnt; b_q = wr_addr_q.size();
    send_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_we_cnt", 32'(we_cnt - b_we), 32'd1);
    chk("post_rst_addr",   wa(b_q), 32'h00);
    chk("post_rst_data",   wd(b_q), 32'h81);
    chk("post_rst_err",    32'(fe_cnt - b_fe), 32'd0);

    // clr coincident with the good stop-bit sample at address 10.
    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 1'b1);
    repeat (4) @(negedge clk);
    chk("pre_clr_addr", 32'(ram_addr), 32'd10);
    b_we = we_cnt; b_fe = fe_cnt; b_fd = fd_cnt; b_q = wr_addr_q.size();
    fork
      send_frame(8'hC3, 1'b1);
      begin
        @(negedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("clr_addr_now", 32'(ram_addr), 32'd0);
        chk("clr_we_now",   32'(ram_we),   32'd0);
        clr = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    chk("clr_we_cnt",   32'(we_cnt - b_we), 32'd0);
    chk("clr_err_cnt",  32'(fe_cnt - b_fe), 32'd0);
    chk("clr_done_cnt", 32'(fd_cnt - b_fd), 32'd0);
    send_frame(8'h99, 1'b1);
    repeat (4) @(negedge clk);
    chk("after_clr_addr", wa(b_q), 32'h00);
    chk("after_clr_data", wd(b_q), 32'h99);
    chk("after_clr_next", 32'(ram_addr), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
